// File: rtl/px_ss_csr_pkg.sv
// px_ss CSR register map plus the cfg-writer sequencing types:
// FSM state enum, write count and the write-list lookup function.
package px_ss_csr_pkg;

  // px_ss CSR word indices (byte address = base + idx*4)
  localparam logic [7:0] PS_PX_SKIP_CR         = 8'd0;
  localparam logic [7:0] PS_PX_INTERVAL_CR     = 8'd1;
  localparam logic [7:0] PS_PX_ADD_INTERVAL_CR = 8'd2;
  localparam logic [7:0] PS_LN_SKIP_CR         = 8'd3;
  localparam logic [7:0] PS_LN_INTERVAL_CR     = 8'd4;
  localparam logic [7:0] PS_LN_ADD_INTERVAL_CR = 8'd5;
  localparam logic [7:0] PS_APPLY_STB_CR       = 8'd6;

  // six settings, then APPLY_STB=1, then APPLY_STB=0 to re-arm the edge detector
  localparam int unsigned PX_SS_CFG_WR_CNT = 8;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_WRITE,
    CFG_WAIT_B,
    CFG_DONE
  } px_ss_cfg_state_t;

  typedef struct packed {
    logic [7:0]  reg_idx;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } px_ss_cfg_wr_t;

  // vals[0..5] = px_to_skip, px_interval, add_px_interval, ln_to_skip, ln_interval, add_ln_interval
  function automatic px_ss_cfg_wr_t px_ss_cfg_wr_item(input logic [2:0] idx,
                                                      input logic [5:0][15:0] vals);
    px_ss_cfg_wr_t item;
    item.wstrb = 4'b0011;
    item.wdata = 32'd0;
    item.reg_idx = PS_APPLY_STB_CR;
    case (idx)
      3'd0: begin item.reg_idx = PS_PX_SKIP_CR;         item.wdata = {16'd0, vals[0]}; end
      3'd1: begin item.reg_idx = PS_PX_INTERVAL_CR;     item.wdata = {16'd0, vals[1]}; end
      3'd2: begin item.reg_idx = PS_PX_ADD_INTERVAL_CR; item.wdata = {16'd0, vals[2]}; end
      3'd3: begin item.reg_idx = PS_LN_SKIP_CR;         item.wdata = {16'd0, vals[3]}; end
      3'd4: begin item.reg_idx = PS_LN_INTERVAL_CR;     item.wdata = {16'd0, vals[4]}; end
      3'd5: begin item.reg_idx = PS_LN_ADD_INTERVAL_CR; item.wdata = {16'd0, vals[5]}; end
      3'd6: begin item.wdata = 32'd1; item.wstrb = 4'b0001; end
      default: begin item.wdata = 32'd0; item.wstrb = 4'b0001; end
    endcase
    return item;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with master/slave views.
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_wr_master.sv
// Single-write AXI4-Lite engine: a req pulse launches AW and W together,
// each valid drops after its own handshake, then bready is raised until the
// B handshake. data_done pulses when both AW and W have completed; ack/resp
// report the B handshake. abort drops everything immediately.
module axi4_lite_wr_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        abort,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [3:0]  strb,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        data_done,
  output logic        ack,
  output logic [1:0]  resp
);
  logic aw_done_reg, w_done_reg;
  logic aw_fire, w_fire;

  assign aw_fire   = awvalid & awready;
  assign w_fire    = wvalid & wready;
  // both address and data accepted, either now or in an earlier cycle
  assign data_done = (awvalid | wvalid) & (aw_done_reg | aw_fire) & (w_done_reg | w_fire);
  assign ack       = bvalid & bready;
  assign resp      = bresp;

  // channel handshake tracking; payload is only reloaded on req so it stays stable while valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awaddr      <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else if (abort) begin
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      if (aw_fire) begin
        awvalid     <= 1'b0;
        aw_done_reg <= 1'b1;
      end
      if (w_fire) begin
        wvalid     <= 1'b0;
        w_done_reg <= 1'b1;
      end
      if (data_done) begin
        bready      <= 1'b1;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end
      if (ack) bready <= 1'b0;
      if (req) begin
        awaddr  <= addr;
        wdata   <= data;
        wstrb   <= strb;
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/px_ss_cfg_writer.sv
// Programs a px_ss CSR block over AXI4-Lite: on start_i snapshots six
// settings and writes them, then pulses APPLY_STB (1 then 0).
// Optional per-write response timeout: define PX_SS_CFG_TIMEOUT_EN.
module px_ss_cfg_writer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [15:0]  px_to_skip_i,
  input  logic [15:0]  px_skip_interval_i,
  input  logic [15:0]  add_px_skip_interval_i,
  input  logic [15:0]  ln_to_skip_i,
  input  logic [15:0]  ln_skip_interval_i,
  input  logic [15:0]  add_ln_skip_interval_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  axi4_lite_if.master  csr_o
);
  import px_ss_csr_pkg::*;

  px_ss_cfg_state_t state_reg, state_next;
  logic [2:0]       idx_reg;
  logic [5:0][15:0] snap_reg;
  logic             err_reg;

  logic             req, abort, data_done, ack, timeout, last;
  logic [1:0]       resp;
  logic [5:0][15:0] live_vals, req_vals;
  logic [2:0]       req_idx;
  px_ss_cfg_wr_t    req_item;
  logic [31:0]      req_addr;

  assign live_vals = {add_ln_skip_interval_i, ln_skip_interval_i, ln_to_skip_i,
                      add_px_skip_interval_i, px_skip_interval_i, px_to_skip_i};
  assign last      = (idx_reg == 3'(PX_SS_CFG_WR_CNT - 1));

  // the engine latches on req, so the payload is for the index about to be issued:
  // write 0 straight from the live inputs (same values the snapshot captures)
  assign req_idx  = (state_reg == CFG_IDLE) ? 3'd0 : idx_reg + 3'd1;
  assign req_vals = (state_reg == CFG_IDLE) ? live_vals : snap_reg;
  assign req_item = px_ss_cfg_wr_item(req_idx, req_vals);
  assign req_addr = BASE_ADDR + {22'd0, req_item.reg_idx, 2'b00};

`ifdef PX_SS_CFG_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;
  logic        in_xfer, entering;
  assign in_xfer  = (state_reg == CFG_WRITE) || (state_reg == CFG_WAIT_B);
  assign entering = (state_next != state_reg) &&
                    ((state_next == CFG_WRITE) || (state_next == CFG_WAIT_B));
  assign timeout  = in_xfer && (tmo_cnt_reg == 16'(TIMEOUT_CYCLES - 1));

  // cycles spent in the current WRITE/WAIT_B visit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         tmo_cnt_reg <= '0;
    else if (entering) tmo_cnt_reg <= '0;
    else if (in_xfer)  tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
  end
`else
  assign timeout = 1'b0;
  wire unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  axi4_lite_wr_master u_wr (
    .clk       (clk_i),
    .rst       (rst_i),
    .req       (req),
    .abort     (abort),
    .addr      (req_addr),
    .data      (req_item.wdata),
    .strb      (req_item.wstrb),
    .awaddr    (csr_o.awaddr),
    .awvalid   (csr_o.awvalid),
    .awready   (csr_o.awready),
    .wdata     (csr_o.wdata),
    .wstrb     (csr_o.wstrb),
    .wvalid    (csr_o.wvalid),
    .wready    (csr_o.wready),
    .bresp     (csr_o.bresp),
    .bvalid    (csr_o.bvalid),
    .bready    (csr_o.bready),
    .data_done (data_done),
    .ack       (ack),
    .resp      (resp)
  );

  // read channel is never used
  assign csr_o.awprot  = 3'b000;
  assign csr_o.araddr  = 32'd0;
  assign csr_o.arprot  = 3'b000;
  assign csr_o.arvalid = 1'b0;
  assign csr_o.rready  = 1'b1;
  wire unused_rd = &{1'b0, csr_o.arready, csr_o.rdata, csr_o.rresp, csr_o.rvalid};

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= CFG_IDLE;
    else       state_reg <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CFG_IDLE:   if (start_i) state_next = CFG_WRITE;
      CFG_WRITE:  if (timeout) state_next = CFG_DONE;
                  else if (data_done) state_next = CFG_WAIT_B;
      CFG_WAIT_B: if (timeout) state_next = CFG_DONE;
                  else if (ack) state_next = last ? CFG_DONE : CFG_WRITE;
      CFG_DONE:   state_next = CFG_IDLE;
      default:    state_next = CFG_IDLE;
    endcase
  end

  // outputs and engine control per state
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    req    = 1'b0;
    abort  = 1'b0;
    case (state_reg)
      CFG_IDLE:   req = start_i;
      CFG_WRITE:  begin busy_o = 1'b1; abort = timeout; end
      CFG_WAIT_B: begin busy_o = 1'b1; abort = timeout; req = ack & ~last & ~timeout; end
      CFG_DONE:   done_o = 1'b1;
      default:    ;
    endcase
  end

  // snapshot, write index and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_reg <= '0;
      idx_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (state_reg == CFG_IDLE && start_i) begin
        snap_reg <= live_vals;
        idx_reg  <= 3'd0;
        err_reg  <= 1'b0;
      end
      if (state_reg == CFG_WAIT_B && ack && !timeout) begin
        if (resp != 2'b00) err_reg <= 1'b1;
        if (!last) idx_reg <= idx_reg + 3'd1;
      end
      if (timeout) err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
endmodule

// File: doc/px_ss_cfg_writer.md
Name: px_ss_cfg_writer

Overview:
AXI4-Lite master that programs one pixel subsampler CSR block from a parallel set of configuration inputs. On a start strobe it snapshots six 16-bit settings and issues eight sequential single-beat writes: six setting registers, then APPLY_STB=1, then APPLY_STB=0 so the subsampler edge-detector is re-armed. It sits between a host/sequencer (or a fixed power-up config) and the px_ss CSR slave on the control interconnect.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the target px_ss CSR block
TIMEOUT_CYCLES, 1024, per-write response timeout, used only when the optional feature is compiled in

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
start_i  input  1  begin a programming sequence; sampled in IDLE only
px_to_skip_i  input  16  value for PS_PX_SKIP_CR
px_skip_interval_i  input  16  value for PS_PX_INTERVAL_CR
add_px_skip_interval_i  input  16  value for PS_PX_ADD_INTERVAL_CR
ln_to_skip_i  input  16  value for PS_LN_SKIP_CR
ln_skip_interval_i  input  16  value for PS_LN_INTERVAL_CR
add_ln_skip_interval_i  input  16  value for PS_LN_ADD_INTERVAL_CR
busy_o  output  1  sequence in progress
done_o  output  1  one-cycle pulse when the sequence completes or aborts
err_o  output  1  sticky: any non-zero bresp (or timeout) in the last sequence; cleared on next accepted start_i
csr_o  interface  -  axi4_lite_if.master, 32-bit data

Behaviour:
- Reset: FSM=IDLE; awvalid, wvalid, arvalid, bready, busy_o, done_o, err_o = 0; awaddr, wdata, wstrb = 0; write index = 0; snapshot regs = 0. rready tied 1, arvalid tied 0 (read channel unused). awprot = 0.
- States: IDLE, WRITE, WAIT_B, DONE.
- IDLE: start_i=1 -> snapshot all six inputs, index=0, err_o cleared, busy_o=1 next cycle, go WRITE. Input changes after the snapshot have no effect.
- WRITE: awvalid and wvalid both driven 1 from the first WRITE cycle (cycle after start_i). awaddr = BASE_ADDR + (reg_idx << 2). Each valid drops independently the cycle after its own handshake; AW and W handshakes may occur in either order or in the same cycle. Both complete -> WAIT_B. awaddr/wdata/wstrb are held stable while either valid is high.
- Write list, reg_idx from px_ss_csr_pkg: PS_PX_SKIP_CR, PS_PX_INTERVAL_CR, PS_PX_ADD_INTERVAL_CR, PS_LN_SKIP_CR, PS_LN_INTERVAL_CR, PS_LN_ADD_INTERVAL_CR (wdata = {16'd0, value}, wstrb = 4'b0011), then PS_APPLY_STB_CR with wdata=1, then PS_APPLY_STB_CR with wdata=0 (wstrb = 4'b0001 for both).
- WAIT_B: bready=1. On the B handshake, bresp != 2'b00 sets err_o. If index < 7: increment and go WRITE. Otherwise go DONE. The sequence never aborts on bresp error.
- DONE: done_o=1 for exactly one cycle, busy_o=0 in the same cycle, then IDLE. The next start_i is accepted at the earliest in the cycle after DONE.
- start_i while busy: ignored, not queued.
- Strictly one outstanding write. Never asserts awvalid before the previous B handshake.
- bvalid arriving before both AW/W handshakes complete is a protocol violation. The FSM ignores it until WAIT_B.
- Reset mid-sequence: all valids deassert immediately (async). No partial-sequence resume.

Optional Feature:
Macro PX_SS_CFG_TIMEOUT_EN.
- With the macro: a 16-bit counter clears on entry to WRITE and WAIT_B and increments every cycle in those states. Reaching TIMEOUT_CYCLES sets err_o, drops all valids and bready, and goes to DONE.
- Without the macro: no counter; the block waits indefinitely.

Decomposition:
- Register indices PS_*_CR come from the existing px_ss_csr_pkg. Do not duplicate them.
- Add to that package: the FSM state enum typedef, a constant PX_SS_CFG_WR_CNT = 8, and a function mapping write index to {reg_idx, wdata, wstrb}.
- Sub-module: axi4_lite_wr_master, a single-write engine covering AW/W independent handshakes and the B capture. It takes req/addr/data/strb and returns ack/resp, and is reusable by other cfg writers. The top-level block holds only the sequencing FSM.

Test Plan:
1. Slave with awready=wready=1 and bvalid one cycle after W; start with inputs 3,7,1,2,5,0 -> eight writes at BASE_ADDR + 0x00..0x18, then 0x18 again; wdata 3,7,1,2,5,0,1,0; done_o pulses once; err_o=0.
2. Slave holds wready=0 for 4 cycles after an AW handshake -> awvalid drops after its handshake, wvalid stays high with stable wdata, and no second awvalid appears before the B handshake.
3. bresp=2'b10 on write 3 -> the sequence still completes all 8 writes; err_o=1 after done_o; err_o clears on the next start_i.
4. start_i pulsed during write 4, and input values changed mid-sequence -> no restart; written data equals the snapshot values.
5. rst_i asserted in WAIT_B of write 5 -> awvalid, wvalid, bready, busy_o go to 0 immediately; a subsequent start_i restarts from PS_PX_SKIP_CR.
6. (PX_SS_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=16) slave never asserts bvalid -> 16 cycles after entering WAIT_B: err_o=1, done_o pulses, FSM returns to IDLE.
